// File: rtl/cmd_fifo_writer_pkg.sv
// Shared definitions for the command FIFO write path: state encoding,
// reset polarity and the minimum recovery time after a write strobe.
package cmd_fifo_writer_pkg;

    // Write-side sequencer states.
    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_SETUP   = 2'd1,
        WR_STROBE  = 2'd2,
        WR_RECOVER = 2'd3
    } wr_state_e;

    // Level of nrst that holds the block in reset.
    localparam logic RESET_ASSERTED = 1'b0;

    // Recovery must cover the two synchronizer flops plus one decision
    // cycle, so the full flag raised by our own write is seen before the
    // next accept.
    localparam int MIN_RECOVER = 3;

    // Width of the blocked-cycle counter.
    localparam int STALL_W = 16;

    // Recovery length actually used by the sequencer.
    function automatic int effective_recover(input int recover_cycles);
        return (recover_cycles > MIN_RECOVER) ? recover_cycles : MIN_RECOVER;
    endfunction

endpackage

// File: rtl/cmd_fifo_writer_sync2.sv
// Two-flop synchronizer for a single asynchronous flag. RST_VAL selects the
// level both stages take in reset, so a flag can be forced to its safe value.
module cmd_fifo_writer_sync2
    import cmd_fifo_writer_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values: first stage samples the raw input, second re-times it.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages with synchronous reset to the safe level.
    always_ff @(posedge clk) begin
        if (nrst == RESET_ASSERTED) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cmd_fifo_writer.sv
// Write side of the external byte-wide command FIFO. Takes bytes from a
// valid/ready producer and drives the FIFO bus with setup / strobe / recovery
// timing; never starts a write while the synchronized full flag is asserted.
module cmd_fifo_writer
    import cmd_fifo_writer_pkg::*;
#(
    parameter int SETUP_CYCLES   = 1,
    parameter int PULSE_CYCLES   = 2,
    parameter int RECOVER_CYCLES = 3,
    parameter int CNT_W          = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        nff_in,
    output logic [7:0]  fifo_data,
    output logic        fifo_data_oe,
    output logic        fifo_nwr,
    output logic        busy,
    output logic [15:0] stall_count
);

    localparam int REC_CYCLES = effective_recover(RECOVER_CYCLES);

    // Counter load values: each phase lasts (load + 1) clocks.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD   = CNT_W'(REC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    wr_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         data_q, data_d;
    logic               oe_q, oe_d;
    logic               nwr_q, nwr_d;
    logic               ready_q, ready_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               nff_s;
    logic               accept;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == {STALL_W{1'b1}}) ? v : v + STALL_W'(1);
    endfunction

    // Full flag is asynchronous; reset value 0 means "full" until proven otherwise.
    cmd_fifo_writer_sync2 #(
        .RST_VAL (1'b0)
    ) u_nff_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (nff_in),
        .q    (nff_s)
    );

    // Handshake completes only from IDLE with the registered ready.
    always_comb begin
        accept = (state_q == WR_IDLE) && wr_valid && ready_q;
    end

    // Sequencer next-state and bus/strobe outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        oe_d    = oe_q;
        nwr_d   = nwr_q;
        ready_d = 1'b0;
        case (state_q)
            WR_IDLE: begin
                if (accept) begin
                    data_d  = wr_data;
                    oe_d    = 1'b1;
                    cnt_d   = SETUP_LOAD;
                    state_d = WR_SETUP;
                end else begin
                    ready_d = nff_s;
                end
            end
            WR_SETUP: begin
                if (cnt_q == '0) begin
                    nwr_d   = 1'b0;
                    cnt_d   = PULSE_LOAD;
                    state_d = WR_STROBE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WR_STROBE: begin
                if (cnt_q == '0) begin
                    nwr_d   = 1'b1;
                    cnt_d   = REC_LOAD;
                    state_d = WR_RECOVER;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WR_RECOVER: begin
                // Data and oe stay up here to give the FIFO its hold time.
                if (cnt_q == '0) begin
                    oe_d    = 1'b0;
                    state_d = WR_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                nwr_d   = 1'b1;
                oe_d    = 1'b0;
                state_d = WR_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset aborts any write in progress immediately.
    always_ff @(posedge clk) begin
        if (nrst == RESET_ASSERTED) begin
            state_q <= WR_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            oe_q    <= 1'b0;
            nwr_q   <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            oe_q    <= oe_d;
            nwr_q   <= nwr_d;
            ready_q <= ready_d;
        end
    end

    // Count idle cycles where the producer is waiting on a full FIFO.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == WR_IDLE) && wr_valid && !nff_s) begin
            stall_d = sat_inc(stall_q);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (nrst == RESET_ASSERTED) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign wr_ready     = ready_q;
    assign fifo_data    = data_q;
    assign fifo_data_oe = oe_q;
    assign fifo_nwr     = nwr_q;
    assign busy         = (state_q != WR_IDLE);
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_cmd_fifo_writer.sv
// Bench for cmd_fifo_writer: instance 0 uses default timing, instance 1 uses
// SETUP=2/PULSE=1/RECOVER=1. Each has a FIFO model driving its full flag and
// a cycle model predicting the outputs from the accept time and phase lengths.
module tb_cmd_fifo_writer;

    logic             clk = 1'b0;
    logic [1:0]       nrst = 2'b00;
    logic [1:0]       wr_valid = 2'b00;
    logic [1:0][7:0]  wr_data = '0;
    logic [1:0]       nff_in = 2'b11;
    logic [1:0]       wr_ready;
    logic [1:0][7:0]  fifo_data;
    logic [1:0]       fifo_data_oe;
    logic [1:0]       fifo_nwr;
    logic [1:0]       busy;
    logic [1:0][15:0] stall_count;

    int n_vec = 0;
    int n_err = 0;
    int e = 0;

    // Phase lengths per instance (recovery already clamped to at least 3).
    int s_cyc[2] = '{1, 2};
    int p_cyc[2] = '{2, 1};
    int r_cyc[2] = '{3, 3};

    // Cycle model state.
    int          ta[2]      = '{-1000, -1000};
    bit          rdy_m[2]   = '{0, 0};
    bit          s1m[2]     = '{0, 0};
    bit          s2m[2]     = '{0, 0};
    logic [15:0] stall_m[2] = '{16'h0, 16'h0};
    logic [7:0]  data_m[2]  = '{8'h0, 8'h0};

    // FIFO model state.
    int   occ[2]     = '{0, 0};
    int   depth[2]   = '{1000, 1000};
    int   popc[2]    = '{0, 0};
    int   popd[2]    = '{0, 0};
    int   strobes[2] = '{0, 0};
    int   lowrun[2]  = '{0, 0};
    int   lastw[2]   = '{0, 0};
    logic nwr_prev[2] = '{1'b1, 1'b1};
    bit   done1 = 0;
    logic [7:0] exp0[$], exp1[$], log0[$], log1[$];
    int         rise0[$];

    cmd_fifo_writer u_dut0 (
        .clk(clk), .nrst(nrst[0]), .wr_valid(wr_valid[0]), .wr_data(wr_data[0]),
        .wr_ready(wr_ready[0]), .nff_in(nff_in[0]), .fifo_data(fifo_data[0]),
        .fifo_data_oe(fifo_data_oe[0]), .fifo_nwr(fifo_nwr[0]), .busy(busy[0]),
        .stall_count(stall_count[0])
    );

    cmd_fifo_writer #(
        .SETUP_CYCLES(2), .PULSE_CYCLES(1), .RECOVER_CYCLES(1), .CNT_W(4)
    ) u_dut1 (
        .clk(clk), .nrst(nrst[1]), .wr_valid(wr_valid[1]), .wr_data(wr_data[1]),
        .wr_ready(wr_ready[1]), .nff_in(nff_in[1]), .fifo_data(fifo_data[1]),
        .fifo_data_oe(fifo_data_oe[1]), .fifo_nwr(fifo_nwr[1]), .busy(busy[1]),
        .stall_count(stall_count[1])
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Advance the model by the clock edge that just passed, compare, then
    // update the FIFO model (capture on nwr rising, pops, full flag).
    task automatic model_step(input int i);
        int lc, k;
        bit idle_b, acc, nr;
        lc = s_cyc[i] + p_cyc[i] + r_cyc[i];
        idle_b = !((e - 1 - ta[i]) >= 0 && (e - 1 - ta[i]) < lc);
        if (nrst[i] == 1'b0) begin
            ta[i] = -1000; rdy_m[i] = 0; s1m[i] = 0; s2m[i] = 0;
            stall_m[i] = 16'h0; data_m[i] = 8'h0;
            if (i == 0) exp0.delete(); else exp1.delete();
        end else begin
            acc = idle_b && wr_valid[i] && rdy_m[i];
            if (idle_b && wr_valid[i] && !s2m[i] && stall_m[i] != 16'hFFFF) stall_m[i] = stall_m[i] + 16'd1;
            nr = idle_b && s2m[i] && !acc;
            if (acc) begin
                ta[i] = e;
                data_m[i] = wr_data[i];
                if (i == 0) exp0.push_back(wr_data[i]); else exp1.push_back(wr_data[i]);
            end
            rdy_m[i] = nr;
            s2m[i] = s1m[i];
            s1m[i] = nff_in[i];
        end
        k = e - ta[i];
        check_val($sformatf("oe%0d", i), 32'(fifo_data_oe[i]), (k >= 0 && k < lc) ? 32'd1 : 32'd0);
        check_val($sformatf("busy%0d", i), 32'(busy[i]), (k >= 0 && k < lc) ? 32'd1 : 32'd0);
        check_val($sformatf("nwr%0d", i), 32'(fifo_nwr[i]),
                  (k >= s_cyc[i] && k < s_cyc[i] + p_cyc[i]) ? 32'd0 : 32'd1);
        check_val($sformatf("ready%0d", i), 32'(wr_ready[i]), 32'(rdy_m[i]));
        check_val($sformatf("data%0d", i), 32'(fifo_data[i]), 32'(data_m[i]));
        check_val($sformatf("stall%0d", i), 32'(stall_count[i]), 32'(stall_m[i]));
        if (nwr_prev[i] === 1'b0 && fifo_nwr[i] === 1'b1) begin
            strobes[i]++;
            lastw[i] = lowrun[i];
            occ[i]++;
            if (i == 0) begin
                log0.push_back(fifo_data[i]);
                rise0.push_back(e);
                if (exp0.size() > 0) check_val("fbyte0", 32'(fifo_data[i]), 32'(exp0.pop_front()));
            end else begin
                log1.push_back(fifo_data[i]);
                if (exp1.size() > 0) check_val("fbyte1", 32'(fifo_data[i]), 32'(exp1.pop_front()));
            end
        end
        if (fifo_nwr[i] === 1'b0) lowrun[i]++; else lowrun[i] = 0;
        nwr_prev[i] = fifo_nwr[i];
        while (popd[i] < popc[i]) begin
            if (occ[i] > 0) occ[i]--;
            popd[i]++;
        end
        nff_in[i] = (occ[i] < depth[i]);
    endtask

    always @(negedge clk) begin
        e++;
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // Offer one byte and wait (bounded) for it to be taken.
    task automatic push(input int i, input logic [7:0] b, input int budget);
        bit ok;
        ok = 0;
        wr_valid[i] = 1'b1;
        wr_data[i] = b;
        for (int n = 0; n < budget; n++) begin
            if (wr_ready[i] === 1'b1) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        if (ok) begin @(negedge clk); #1; end
        wr_valid[i] = 1'b0;
        if (!ok) check_val($sformatf("push_timeout%0d", i), 32'd0, 32'd1);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Instance 0: directed scenarios, then random traffic.
    initial begin : main_seq
        int base, waited;
        #1;
        wait_cyc(4);
        check_val("rst_nwr", 32'(fifo_nwr[0]), 32'd1);
        check_val("rst_oe", 32'(fifo_data_oe[0]), 32'd0);
        check_val("rst_ready", 32'(wr_ready[0]), 32'd0);
        nrst[0] = 1'b1;
        wait_cyc(3);
        check_val("ready_after_rst", 32'(wr_ready[0]), 32'd1);

        // Single write.
        base = strobes[0];
        push(0, 8'hA5, 50);
        wait_cyc(10);
        check_val("single_strobes", 32'(strobes[0] - base), 32'd1);
        check_val("single_width", 32'(lastw[0]), 32'd2);
        check_val("single_byte", (log0.size() > 0) ? 32'(log0[log0.size() - 1]) : 32'hFFFF, 32'hA5);

        // Back-to-back burst with wr_valid held high.
        base = strobes[0];
        for (int b = 0; b < 16; b++) push(0, 8'(b), 50);
        wait_cyc(10);
        check_val("burst_strobes", 32'(strobes[0] - base), 32'd16);
        if (log0.size() >= 16 && rise0.size() >= 16) begin
            for (int j = 0; j < 16; j++)
                check_val($sformatf("burst_byte%0d", j), 32'(log0[log0.size() - 16 + j]), 32'(j));
            for (int j = 1; j < 16; j++)
                check_val($sformatf("burst_gap%0d", j),
                          32'(rise0[rise0.size() - 16 + j] - rise0[rise0.size() - 17 + j]), 32'd8);
        end else begin
            check_val("burst_log", 32'(log0.size()), 32'd16);
        end

        // Full handling with a 4-deep FIFO and no reads.
        depth[0] = 4;
        popc[0] += occ[0];
        wait_cyc(5);
        base = strobes[0];
        for (int b = 0; b < 4; b++) push(0, 8'(8'h40 + b), 50);
        wr_valid[0] = 1'b1;
        wr_data[0] = 8'h44;
        wait_cyc(30);
        check_val("full_strobes", 32'(strobes[0] - base), 32'd4);
        check_val("full_ready", 32'(wr_ready[0]), 32'd0);
        check_val("full_stalled", (stall_count[0] != 16'd0) ? 32'd1 : 32'd0, 32'd1);
        popc[0]++;
        waited = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk); #1;
            waited = n;
            if (strobes[0] - base == 5) break;
        end
        check_val("unfull_latency_ok", (strobes[0] - base == 5 && waited <= 8) ? 32'd1 : 32'd0, 32'd1);
        wr_data[0] = 8'h66;
        wait_cyc(20);
        check_val("refull_strobes", 32'(strobes[0] - base), 32'd5);
        popc[0] += occ[0];
        for (int n = 0; n < 30 && strobes[0] - base < 6; n++) begin
            @(negedge clk); #1;
        end
        wr_valid[0] = 1'b0;
        check_val("sixth_written", 32'(strobes[0] - base), 32'd6);
        check_val("sixth_byte", (log0.size() > 0) ? 32'(log0[log0.size() - 1]) : 32'hFFFF, 32'h66);
        depth[0] = 1000;
        popc[0] += occ[0];
        wait_cyc(5);

        // Reset on the second strobe-low cycle aborts the write.
        push(0, 8'hB7, 50);
        @(negedge clk);
        @(negedge clk); #1;
        nrst[0] = 1'b0;
        wait_cyc(1);
        check_val("abort_nwr", 32'(fifo_nwr[0]), 32'd1);
        check_val("abort_oe", 32'(fifo_data_oe[0]), 32'd0);
        base = strobes[0];
        nrst[0] = 1'b1;
        wait_cyc(20);
        check_val("abort_no_strobe", 32'(strobes[0] - base), 32'd0);

        // Random traffic against a small FIFO with random reads.
        depth[0] = 4;
        for (int n = 0; n < 400; n++) begin
            wr_valid[0] = 1'($urandom_range(0, 1));
            wr_data[0] = 8'($urandom);
            if ($urandom_range(0, 2) == 0) popc[0]++;
            wait_cyc(1);
        end
        wr_valid[0] = 1'b0;
        popc[0] += occ[0];
        wait_cyc(20);

        for (int n = 0; n < 3000 && !done1; n++) wait_cyc(1);
        check_val("inst1_done", 32'(done1), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Instance 1: non-default timing, then random traffic.
    initial begin : alt_seq
        #1;
        wait_cyc(4);
        nrst[1] = 1'b1;
        wait_cyc(3);
        push(1, 8'h3C, 50);
        wait_cyc(10);
        check_val("alt_strobes", 32'(strobes[1]), 32'd1);
        check_val("alt_width", 32'(lastw[1]), 32'd1);
        check_val("alt_byte", (log1.size() > 0) ? 32'(log1[log1.size() - 1]) : 32'hFFFF, 32'h3C);
        depth[1] = 3;
        for (int n = 0; n < 400; n++) begin
            wr_valid[1] = 1'($urandom_range(0, 1));
            wr_data[1] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) popc[1]++;
            wait_cyc(1);
        end
        wr_valid[1] = 1'b0;
        wait_cyc(20);
        done1 = 1;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "timeout");
    end

endmodule
